// File: rtl/wheel_speed_sensor.sv
// Wheel-encoder front end: synchronises and qualifies encoder pulses, counts them per gate window.
// Optional 4-window moving average on wheel_speed when WHEEL_SPEED_FILTER_EN is defined.
`timescale 1ns/1ps
module wheel_speed_sensor #(
    parameter int unsigned WINDOW_CYCLES = 1000,
    parameter int unsigned MIN_HIGH      = 2,
    parameter int unsigned STALL_WINDOWS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enc_pulse,
    output logic [7:0] wheel_speed,
    output logic       speed_valid,
    output logic       stalled
);

    localparam int unsigned      WIN_W      = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST   = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [3:0]       MIN_HIGH_C = 4'(MIN_HIGH);
    localparam logic [3:0]       STALL_C    = 4'(STALL_WINDOWS);

    typedef enum logic [1:0] {
        ST_LOW,
        ST_ARM,
        ST_COUNTED
    } state_t;

    logic             sync_q;
    logic             enc_s_q;
    state_t           state_q, state_d;
    logic [3:0]       run_q, run_d;
    logic             pulse_ok;
    logic [WIN_W-1:0] win_q, win_d;
    logic             win_end;
    logic [8:0]       cnt_q, cnt_d;
    logic [8:0]       cnt_incl;
    logic [7:0]       raw;
    logic [3:0]       stall_q, stall_d;
    logic [7:0]       speed_q, speed_d;
    logic             valid_q;
    logic             stalled_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= 1'b0;
            enc_s_q <= 1'b0;
        end else begin
            sync_q  <= enc_pulse;
            enc_s_q <= sync_q;
        end
    end

    // Pulse qualifier: a pulse is accepted once enc_s has been high MIN_HIGH cycles in a row.
    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        pulse_ok = 1'b0;
        unique case (state_q)
            ST_LOW: begin
                if (enc_s_q) begin
                    run_d = 4'd1;
                    if (MIN_HIGH_C == 4'd1) begin
                        pulse_ok = 1'b1;
                        state_d  = ST_COUNTED;
                    end else begin
                        state_d  = ST_ARM;
                    end
                end
            end
            ST_ARM: begin
                if (!enc_s_q) begin
                    state_d = ST_LOW;
                end else begin
                    run_d = run_q + 4'd1;
                    if (run_d == MIN_HIGH_C) begin
                        pulse_ok = 1'b1;
                        state_d  = ST_COUNTED;
                    end
                end
            end
            ST_COUNTED: begin
                if (!enc_s_q) begin
                    state_d = ST_LOW;
                end
            end
            default: state_d = ST_LOW;
        endcase
    end

    assign win_end = (win_q == WIN_LAST);

    // A pulse_ok coinciding with win_end is folded into the closing window's sample.
    always_comb begin
        win_d    = win_end ? '0 : win_q + WIN_W'(1);
        cnt_incl = cnt_q;
        if (pulse_ok && (cnt_q != 9'd511)) begin
            cnt_incl = cnt_q + 9'd1;
        end
        raw   = cnt_incl[8] ? 8'hFF : cnt_incl[7:0];
        cnt_d = win_end ? '0 : cnt_incl;
    end

    always_comb begin
        stall_d = stall_q;
        if (win_end) begin
            if (raw != 8'd0) begin
                stall_d = '0;
            end else if (stall_q != STALL_C) begin
                stall_d = stall_q + 4'd1;
            end
        end
    end

`ifdef WHEEL_SPEED_FILTER_EN
    logic [2:0][7:0] hist_q;
    logic [9:0]      sum;

    assign sum     = 10'(raw) + 10'(hist_q[0]) + 10'(hist_q[1]) + 10'(hist_q[2]);
    assign speed_d = 8'(sum >> 2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
        end else if (win_end) begin
            hist_q[0] <= raw;
            hist_q[1] <= hist_q[0];
            hist_q[2] <= hist_q[1];
        end
    end
`else
    assign speed_d = raw;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_LOW;
            run_q     <= '0;
            win_q     <= '0;
            cnt_q     <= '0;
            stall_q   <= '0;
            speed_q   <= '0;
            valid_q   <= 1'b0;
            stalled_q <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            valid_q <= win_end;
            if (win_end) begin
                speed_q   <= speed_d;
                stalled_q <= (stall_d == STALL_C);
            end
        end
    end

    assign wheel_speed = speed_q;
    assign speed_valid = valid_q;
    assign stalled     = stalled_q;

endmodule
